// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the multi-lane MAC processing element.
//   cnt_w()       : width of the per-window beat counter
//   acc_w()       : accumulator width that cannot overflow for a full window
//   round_shift() : round-half-up arithmetic right shift
//   sat_ovf()     : 1 when a value lies outside a signed out_w range
//   sat()         : clamp a value into a signed out_w range
package pe_pkg;

  // Working width for the quantiser. It must be at least as wide as the
  // accumulator plus one bit of rounding headroom.
  localparam int QW = 64;

  // Per-beat tag that travels down the pipeline beside the data.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

  function automatic int cnt_w(input int max_taps);
    return $clog2(max_taps + 1);
  endfunction

  function automatic int acc_w(input int data_w, input int wgt_w,
                               input int lanes, input int max_taps);
    return data_w + wgt_w + $clog2(lanes * max_taps);
  endfunction

  // (v + half_lsb) >>> sh. A shift of 0 adds no bias.
  function automatic logic signed [QW-1:0] round_shift(input logic signed [QW-1:0] v,
                                                       input logic [5:0] sh);
    logic signed [QW-1:0] bias;
    bias = '0;
    if (sh != 6'd0) bias = 64'sd1 <<< (sh - 6'd1);
    return (v + bias) >>> sh;
  endfunction

  function automatic logic sat_ovf(input logic signed [QW-1:0] r, input int out_w);
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (r > hi) || (r < lo);
  endfunction

  function automatic logic signed [QW-1:0] sat(input logic signed [QW-1:0] r, input int out_w);
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// One registered signed multiplier with a pipeline enable.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : 1 = capture a new product, 0 = hold
//   a, b     : signed operands
//   p        : registered signed product, A_W+B_W bits (full precision)
module pe_mul_pipe #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= (A_W+B_W)'(a) * (A_W+B_W)'(b);
    end
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// LANES-wide signed MAC processing element with a runtime-programmable window.
// Each accepted beat supplies LANES pixel/weight pairs; the products are
// summed across lanes and accumulated over cfg_taps beats. The window sum is
// presented at full precision (out_acc) and rounded/shifted/saturated (out_q).
//
// Pipeline: S0 accept + tag, S1 products, S2 lane sum, S3 accumulate/output.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready. A producer holds valid and its payload until the transfer;
// ready may depend on state but never on the partner's valid. Here the whole
// pipeline stalls (en=0) while out_valid && !out_ready, and in_ready = en.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_taps                 beats per window (0 -> 1, >MAX_TAPS -> MAX_TAPS),
//                            sampled on the first beat of each window
//   cfg_shift, cfg_sat_en    quantiser controls, change only while busy=0
//   in_valid/in_ready        input beat handshake
//   in_pic, in_wgt           lane i at [i*W +: W], signed
//   out_valid/out_ready      result handshake, result held until accepted
//   out_acc                  full-precision window sum
//   out_q, out_ovf           quantised result and out-of-range flag
//   busy                     partial window, beat in flight, or result pending
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int  LANES    = 4,
  parameter int  DATA_W   = 16,
  parameter int  WGT_W    = 16,
  parameter int  MAX_TAPS = 25,
  parameter int  OUT_W    = 16,
  localparam int CNT_W    = cnt_w(MAX_TAPS),
  localparam int ACC_W    = acc_w(DATA_W, WGT_W, LANES, MAX_TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          cfg_taps,
  input  logic [5:0]                cfg_shift,
  input  logic                      cfg_sat_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_pic,
  input  logic [LANES*WGT_W-1:0]    in_wgt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_acc,
  output logic signed [OUT_W-1:0]   out_q,
  output logic                      out_ovf,
  output logic                      busy
);

  localparam int PROD_W = DATA_W + WGT_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam logic [CNT_W-1:0] MAX_TAPS_C = CNT_W'(MAX_TAPS);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  logic en;
  logic in_fire;

  // ---------------- S0: accept, window counter, tags ----------------
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] taps_q;
  logic [CNT_W-1:0] cfg_taps_eff;
  logic [CNT_W-1:0] taps_cur;
  logic             beat_first;
  logic             beat_last;
  beat_tag_t        s1_tag;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !rst;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    cfg_taps_eff = cfg_taps;
    if (cfg_taps == '0) begin
      cfg_taps_eff = ONE_C;
    end else if (cfg_taps > MAX_TAPS_C) begin
      cfg_taps_eff = MAX_TAPS_C;
    end
    // The first beat of a window uses the live config; later beats use the
    // copy captured on that first beat.
    taps_cur   = (in_cnt == '0) ? cfg_taps_eff : taps_q;
    beat_first = (in_cnt == '0);
    beat_last  = (in_cnt == taps_cur - ONE_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
      taps_q <= ONE_C;
      s1_tag <= '0;
    end else if (en) begin
      s1_tag.valid <= in_fire;
      s1_tag.first <= beat_first;
      s1_tag.last  <= beat_last;
      if (in_fire) begin
        if (beat_first) taps_q <= cfg_taps_eff;
        in_cnt <= beat_last ? '0 : in_cnt + ONE_C;
      end
    end
  end

  // ---------------- S1: per-lane registered products ----------------
  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mul_pipe #(
      .A_W (DATA_W),
      .B_W (WGT_W)
    ) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (in_pic[i*DATA_W +: DATA_W]),
      .b   (in_wgt[i*WGT_W +: WGT_W]),
      .p   (prod[i])
    );
  end

  // ---------------- S2: lane sum ----------------
  logic signed [SUM_W-1:0] tree_sum;
  logic signed [SUM_W-1:0] s2_sum;
  beat_tag_t               s2_tag;

  // Each product is sign-extended to SUM_W, which has log2(LANES) guard bits.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'(prod[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_tag <= '0;
      s2_sum <= '0;
    end else if (en) begin
      s2_tag <= s1_tag;
      s2_sum <= tree_sum;
    end
  end

  // ---------------- S3: accumulator, quantiser, output register ----------------
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [QW-1:0]    r_wide;
  logic signed [OUT_W-1:0] q_next;
  logic                    ovf_next;

  // A first-tagged beat reloads the accumulator, so back-to-back windows
  // never carry residue from the previous one.
  always_comb begin
    acc_next = s2_tag.first ? ACC_W'(s2_sum) : acc + ACC_W'(s2_sum);
    r_wide   = round_shift(QW'(acc_next), cfg_shift);
    ovf_next = sat_ovf(r_wide, OUT_W);
    q_next   = OUT_W'(cfg_sat_en ? sat(r_wide, OUT_W) : r_wide);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_q     <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (en && s2_tag.valid) acc <= acc_next;
      // A new result may land in the same cycle the old one is taken; en is
      // only high here when the old result is being accepted or absent.
      if (en && s2_tag.valid && s2_tag.last) begin
        out_valid <= 1'b1;
        out_acc   <= acc_next;
        out_q     <= q_next;
        out_ovf   <= ovf_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (in_cnt != '0) || s1_tag.valid || s2_tag.valid || out_valid;

endmodule

// File: tb/tb_pe_mac_lanes.sv
module tb_pe_mac_lanes;

  localparam int ACC_W = 39;
  localparam int OUT_W = 16;
  localparam int EW    = ACC_W + OUT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [4:0]              cfg_taps = 5'd1;
  logic [5:0]              cfg_shift = 6'd0;
  logic                    cfg_sat_en = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [63:0]             in_pic = '0;
  logic [63:0]             in_wgt = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [ACC_W-1:0] out_acc;
  logic signed [OUT_W-1:0] out_q;
  logic                    out_ovf;
  logic                    busy;

  pe_mac_lanes dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_taps   (cfg_taps),
    .cfg_shift  (cfg_shift),
    .cfg_sat_en (cfg_sat_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pic     (in_pic),
    .in_wgt     (in_wgt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_q      (out_q),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int last_acc_cyc = 0;
  logic [EW-1:0] exp_q[$];

  logic [EW-1:0]           mon_e;
  logic signed [ACC_W-1:0] mon_acc;
  logic signed [OUT_W-1:0] mon_q;

  task automatic check_int(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got acc=%0d q=%0d ovf=%0b with nothing pending",
                 out_acc, out_q, out_ovf);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_acc = mon_e[EW-1:OUT_W+1];
        mon_q   = mon_e[OUT_W:1];
        if ({out_acc, out_q, out_ovf} !== mon_e) begin
          n_fail++;
          $display("FAIL result: got acc=%0d q=%0d ovf=%0b, expected acc=%0d q=%0d ovf=%0b",
                   out_acc, out_q, out_ovf, mon_acc, mon_q, mon_e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_beat(input logic [63:0] pic, input logic [63:0] wgt);
    int t;
    logic done;
    in_valid = 1'b1;
    in_pic   = pic;
    in_wgt   = wgt;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        last_acc_cyc = cyc;
        done = 1'b1;
      end else if (t >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_accept_timeout: in_ready low for %0d cycles", t);
        done = 1'b1;
      end
      t++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b, %0d results still pending", busy, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lane0(input int v);
    logic [63:0] r;
    r = '0;
    r[15:0] = 16'(v);
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int         taps;
    logic [5:0] shift;
    logic       sat_en;
    logic       all_lanes;
    int         pic;
    int         wgt;
    longint     exp_acc;
    int         exp_q;
    logic       exp_ovf;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v, input string nm);
    int beats;
    int t;
    logic seen;
    logic [63:0] pv;
    logic [63:0] wv;
    logic [15:0] p16;
    logic [15:0] w16;
    cfg_taps   = 5'(v.taps);
    cfg_shift  = v.shift;
    cfg_sat_en = v.sat_en;
    beats = (v.taps == 0) ? 1 : ((v.taps > 25) ? 25 : v.taps);
    p16 = 16'(v.pic);
    w16 = 16'(v.wgt);
    pv = '0;
    wv = '0;
    for (int l = 0; l < 4; l++) begin
      if (v.all_lanes || l == 0) begin
        pv[l*16 +: 16] = p16;
        wv[l*16 +: 16] = w16;
      end
    end
    exp_q.push_back({ACC_W'(v.exp_acc), OUT_W'(v.exp_q), v.exp_ovf});
    for (int b = 0; b < beats; b++) send_beat(pv, wv);
    seen = 1'b0;
    t = 0;
    while (!seen && t < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else t++;
    end
    check_int({nm, "_latency"}, seen ? longint'(cyc - last_acc_cyc) : -1, 3);
    wait_idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //           taps shift sat  all  pic     wgt     acc                     q       ovf
    vecs[0]  = '{25, 6'd0, 1'b1, 1'b1, 1,      1,      64'sd100,               100,    1'b0};
    vecs[1]  = '{25, 6'd0, 1'b1, 1'b1, -32768, -32768, 64'sd107374182400,      32767,  1'b1};
    vecs[2]  = '{25, 6'd0, 1'b0, 1'b1, -32768, -32768, 64'sd107374182400,      0,      1'b1};
    vecs[3]  = '{0,  6'd1, 1'b1, 1'b0, 5,      1,      64'sd5,                 3,      1'b0};
    vecs[4]  = '{0,  6'd1, 1'b1, 1'b0, -5,     1,      -64'sd5,                -2,     1'b0};
    vecs[5]  = '{0,  6'd2, 1'b1, 1'b0, -6,     1,      -64'sd6,                -1,     1'b0};
    vecs[6]  = '{3,  6'd4, 1'b1, 1'b1, 100,    -7,     -64'sd8400,             -525,   1'b0};
    vecs[7]  = '{1,  6'd0, 1'b0, 1'b0, 300,    300,    64'sd90000,             24464,  1'b1};
    vecs[8]  = '{1,  6'd2, 1'b1, 1'b0, 300,    300,    64'sd90000,             22500,  1'b0};
    vecs[9]  = '{30, 6'd0, 1'b1, 1'b1, 2,      3,      64'sd600,               600,    1'b0};
    vecs[10] = '{1,  6'd0, 1'b1, 1'b1, -32768, 32767,  -64'sd4294836224,       -32768, 1'b1};
    vecs[11] = '{1,  6'd1, 1'b1, 1'b0, -3,     1,      -64'sd3,                -1,     1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_out_valid", out_valid, 0);
    check_int("rst_out_acc",   out_acc,   0);
    check_int("rst_out_q",     out_q,     0);
    check_int("rst_out_ovf",   out_ovf,   0);
    check_int("rst_busy",      busy,      0);
    check_int("rst_in_ready",  in_ready,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Table-driven windows
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back 2-tap windows; cfg_taps wiggles mid-window and is ignored
    cfg_shift  = 6'd0;
    cfg_sat_en = 1'b1;
    cfg_taps   = 5'd2;
    exp_q.push_back({ACC_W'(3), OUT_W'(3), 1'b0});
    exp_q.push_back({ACC_W'(7), OUT_W'(7), 1'b0});
    send_beat(lane0(1), lane0(1));
    cfg_taps = 5'd7;
    send_beat(lane0(2), lane0(1));
    cfg_taps = 5'd2;
    send_beat(lane0(3), lane0(1));
    cfg_taps = 5'd9;
    send_beat(lane0(4), lane0(1));
    wait_idle();

    // Output back-pressure: four 1-tap windows, out_ready low for 10 cycles
    begin
      int t;
      logic seen;
      cfg_taps  = 5'd1;
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) exp_q.push_back({ACC_W'(10*k), OUT_W'(10*k), 1'b0});
      send_beat(lane0(10), lane0(1));
      send_beat(lane0(20), lane0(1));
      send_beat(lane0(30), lane0(1));
      in_valid = 1'b1;
      in_pic   = lane0(40);
      in_wgt   = lane0(1);
      seen = 1'b0;
      t = 0;
      while (!seen && t < 20) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        else t++;
      end
      check_int("stall_valid_seen", seen, 1);
      for (int c = 0; c < 10; c++) begin
        check_int("stall_in_ready", in_ready, 0);
        check_int("stall_out_acc", out_acc, 10);
        check_int("stall_out_q", out_q, 10);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      seen = 1'b0;
      t = 0;
      while (!seen && t < 50) begin
        @(negedge clk);
        if (in_ready) seen = 1'b1;
        else t++;
      end
      check_int("stall_release_accept", seen, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_idle();
    end

    // Reset mid-window discards the partial sum
    cfg_taps = 5'd25;
    for (int b = 0; b < 10; b++) send_beat(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("midrst_busy", busy, 0);
    check_int("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    run_vec(vecs[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
